// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared widths, VC encodings and helpers for the cardinal local port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cardinal_pkg;

  localparam int DATA_W   = 64;  // packet width
  localparam int VC_BIT   = 0;   // packet bit carrying the virtual channel
  localparam int NUM_VC   = 2;
  localparam int VC_IDX_W = 1;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef logic [VC_IDX_W-1:0] vc_t;

  // Virtual channel a packet travels on.
  function automatic vc_t pkt_vc(input logic [DATA_W-1:0] pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/cardinal_vc_buf2.sv
// cardinal_vc_buf2: two one-entry packet buffers (one per VC) with full flags.
// Latency: write visible as full the cycle after the edge; read data is a combinational mux.
// Backpressure: a write to a full buffer is discarded; set wins over clear on one edge.
module cardinal_vc_buf2
  import cardinal_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  vc_t               rd_vc,
  output logic [DATA_W-1:0] rd_dat,
  output logic [NUM_VC-1:0] full
);

  logic [DATA_W-1:0] buf_q [NUM_VC];
  vc_t               wr_vc;
  logic              wr_ok;

  assign wr_vc  = pkt_vc(wr_dat);
  assign wr_ok  = wr_en && !full[wr_vc];
  assign rd_dat = buf_q[rd_vc];

  // Full flags: fill when accepted, clear when drained; a fill beats a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_ok && (wr_vc == vc_t'(v))) begin
          full[v] <= 1'b1;
        end else if (rd_en && (rd_vc == vc_t'(v))) begin
          full[v] <= 1'b0;
        end
      end
    end
  end

  // Packet storage; contents are meaningless while the matching flag is clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      buf_q[wr_vc] <= wr_dat;
    end
  end

endmodule

// File: rtl/cardinal_local_port.sv
// cardinal_local_port: router-side NIC link endpoint with per-VC ingress/egress buffers.
// Latency: one edge to buffer, outputs registered; forwarding waits for the right polarity phase.
// Backpressure: net_ro/fab_ri advertise buffer space; optional counters under PORT_STATS_EN.
module cardinal_local_port
  import cardinal_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              net_polarity,
  input  logic              net_so,
  output logic              net_ro,
  input  logic [DATA_W-1:0] net_do,
  output logic              net_si,
  input  logic              net_ri,
  output logic [DATA_W-1:0] net_di,
  output logic              fab_so,
  input  logic              fab_ro,
  output logic [DATA_W-1:0] fab_do,
  input  logic              fab_si,
  output logic [1:0]        fab_ri,
  input  logic [DATA_W-1:0] fab_di
`ifdef PORT_STATS_EN
  ,
  output logic [15:0]       stat_in_cnt,
  output logic [15:0]       stat_out_cnt,
  output logic [15:0]       stat_drop_cnt
`endif
);

  logic [NUM_VC-1:0] ing_full;
  logic [NUM_VC-1:0] egr_full;
  logic [DATA_W-1:0] ing_rd_dat;
  logic [DATA_W-1:0] egr_rd_dat;
  vc_t               fwd_vc;
  vc_t               dlv_vc;
  logic              fwd;
  logic              dlv;

  // Core transfers use the VC opposite the link polarity; the link uses the matching one.
  assign fwd_vc = ~net_polarity;
  assign dlv_vc = net_polarity;
  assign fwd    = ing_full[fwd_vc] && fab_ro;
  assign dlv    = egr_full[dlv_vc] && net_ri && !net_si;

  assign net_ro = !ing_full[net_polarity];
  assign fab_ri = ~egr_full;

  cardinal_vc_buf2 u_ing (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (net_so),
    .wr_dat (net_do),
    .rd_en  (fwd),
    .rd_vc  (fwd_vc),
    .rd_dat (ing_rd_dat),
    .full   (ing_full)
  );

  cardinal_vc_buf2 u_egr (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (fab_si),
    .wr_dat (fab_di),
    .rd_en  (dlv),
    .rd_vc  (dlv_vc),
    .rd_dat (egr_rd_dat),
    .full   (egr_full)
  );

  // Polarity toggles every cycle; send strobes pulse per transfer, data holds between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      net_polarity <= 1'b0;
      net_si       <= 1'b0;
      net_di       <= '0;
      fab_so       <= 1'b0;
      fab_do       <= '0;
    end else begin
      net_polarity <= ~net_polarity;
      fab_so       <= fwd;
      net_si       <= dlv;
      if (fwd) begin
        fab_do <= ing_rd_dat;
      end
      if (dlv) begin
        net_di <= egr_rd_dat;
      end
    end
  end

`ifdef PORT_STATS_EN
  logic ing_drop;
  logic ing_acc;
  logic egr_drop;

  assign ing_acc  = net_so && !ing_full[pkt_vc(net_do)];
  assign ing_drop = net_so &&  ing_full[pkt_vc(net_do)];
  assign egr_drop = fab_si &&  egr_full[pkt_vc(fab_di)];

  // Traffic counters, free-running modulo 2^16.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_in_cnt   <= '0;
      stat_out_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      stat_in_cnt   <= stat_in_cnt + 16'(ing_acc);
      stat_out_cnt  <= stat_out_cnt + 16'(dlv);
      stat_drop_cnt <= stat_drop_cnt + 16'(ing_drop) + 16'(egr_drop);
    end
  end
`endif

endmodule

// File: tb/tb_cardinal_local_port.sv
// tb_cardinal_local_port: directed stimulus with per-VC scoreboards for both output directions.
// Latency: n/a.
// Backpressure: n/a.
module tb_cardinal_local_port;
  import cardinal_pkg::*;

  logic              clk;
  logic              reset;
  logic              net_polarity;
  logic              net_so;
  logic              net_ro;
  logic [DATA_W-1:0] net_do;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;
  logic              fab_so;
  logic              fab_ro;
  logic [DATA_W-1:0] fab_do;
  logic              fab_si;
  logic [1:0]        fab_ri;
  logic [DATA_W-1:0] fab_di;
`ifdef PORT_STATS_EN
  logic [15:0]       stat_in_cnt;
  logic [15:0]       stat_out_cnt;
  logic [15:0]       stat_drop_cnt;
`endif

  cardinal_local_port dut (
    .clk          (clk),
    .reset        (reset),
    .net_polarity (net_polarity),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .fab_so       (fab_so),
    .fab_ro       (fab_ro),
    .fab_do       (fab_do),
    .fab_si       (fab_si),
    .fab_ri       (fab_ri),
    .fab_di       (fab_di)
`ifdef PORT_STATS_EN
    ,
    .stat_in_cnt  (stat_in_cnt),
    .stat_out_cnt (stat_out_cnt),
    .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_pol = 1'b0;
  logic prev_si = 1'b0;

  logic [DATA_W-1:0] fab_q0 [$];
  logic [DATA_W-1:0] fab_q1 [$];
  logic [DATA_W-1:0] net_q0 [$];
  logic [DATA_W-1:0] net_q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return fab_q0.size() + fab_q1.size() + net_q0.size() + net_q1.size();
  endfunction

  // One clock; afterwards inputs may be driven and outputs sampled.
  task automatic step();
    @(posedge clk);
    #1;
    exp_pol = reset ? 1'b0 : ~exp_pol;
    chk("polarity", net_polarity, exp_pol);
  endtask

  task automatic wait_pol(input logic p);
    if (exp_pol != p) step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    @(negedge clk);
    #1;
    chk("drain_timeout_pending", pending(), 0);
  endtask

  // Output monitor: every send pulse must match the head of its VC's scoreboard.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (fab_so === 1'b1) begin
      if (fab_do[VC_BIT] == 1'b0) begin
        if (fab_q0.size() == 0) chk("fab_unexpected_vc0", fab_do, 64'h0);
        else begin e = fab_q0.pop_front(); chk("fab_do_vc0", fab_do, e); end
      end else begin
        if (fab_q1.size() == 0) chk("fab_unexpected_vc1", fab_do, 64'h0);
        else begin e = fab_q1.pop_front(); chk("fab_do_vc1", fab_do, e); end
      end
    end
    if (net_si === 1'b1) begin
      chk("net_si_back_to_back", prev_si, 1'b0);
      if (net_di[VC_BIT] == 1'b0) begin
        if (net_q0.size() == 0) chk("net_unexpected_vc0", net_di, 64'h0);
        else begin e = net_q0.pop_front(); chk("net_di_vc0", net_di, e); end
      end else begin
        if (net_q1.size() == 0) chk("net_unexpected_vc1", net_di, 64'h0);
        else begin e = net_q1.pop_front(); chk("net_di_vc1", net_di, e); end
      end
    end
    prev_si = net_si;
  end

  initial begin
    reset  = 1'b1;
    net_so = 1'b0;
    net_do = '0;
    net_ri = 1'b0;
    fab_ro = 1'b0;
    fab_si = 1'b0;
    fab_di = '0;

    // Reset and idle
    step();
    step();
    chk("rst_net_si", net_si, 1'b0);
    chk("rst_fab_so", fab_so, 1'b0);
    chk("rst_net_di", net_di, 64'h0);
    chk("rst_fab_do", fab_do, 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_net_ro", net_ro, 1'b1);
      chk("idle_fab_ri", fab_ri, 2'b11);
      chk("idle_net_si", net_si, 1'b0);
      chk("idle_fab_so", fab_so, 1'b0);
      step();
    end

    // NIC -> core, VC0 packet sent on polarity 1
    wait_pol(1'b1);
    fab_ro = 1'b1;
    net_so = 1'b1;
    net_do = 64'h0000_0000_0000_00A2;
    fab_q0.push_back(64'h0000_0000_0000_00A2);
    step();
    net_so = 1'b0;
    chk("ing0_full_ro", net_ro, 1'b0);
    drain(8);
    chk("ing0_after_drain_ro", net_ro, 1'b1);

    // Core -> NIC, VC1 packet
    net_ri = 1'b1;
    fab_si = 1'b1;
    fab_di = 64'h0000_0000_0000_00B3;
    net_q1.push_back(64'h0000_0000_0000_00B3);
    step();
    fab_si = 1'b0;
    chk("egr1_full_ri", fab_ri, 2'b01);
    drain(8);
    chk("egr1_ri_back", fab_ri, 2'b11);

    // Two VC0 packets back-to-back: the second hits a full buffer
    fab_si = 1'b1;
    fab_di = 64'h0000_0000_0000_00C0;
    net_q0.push_back(64'h0000_0000_0000_00C0);
    step();
    chk("egr0_full_ri", fab_ri, 2'b10);
    fab_di = 64'h0000_0000_0000_00C2;
    step();
    fab_si = 1'b0;
    drain(8);
    repeat (3) step();
`ifdef PORT_STATS_EN
    chk("stat_drop_after_b2b", stat_drop_cnt, 16'd1);
    chk("stat_in_after_b2b", stat_in_cnt, 16'd1);
    chk("stat_out_after_b2b", stat_out_cnt, 16'd2);
`endif

    // Both egress buffers full, then NIC ready: deliveries must not be adjacent
    net_ri = 1'b0;
    fab_si = 1'b1;
    fab_di = 64'h0000_0000_0000_00D0;
    net_q0.push_back(64'h0000_0000_0000_00D0);
    step();
    fab_di = 64'h0000_0000_0000_00D1;
    net_q1.push_back(64'h0000_0000_0000_00D1);
    step();
    fab_si = 1'b0;
    chk("egr_both_full_ri", fab_ri, 2'b00);
    net_ri = 1'b1;
    drain(10);
    chk("egr_both_ri_back", fab_ri, 2'b11);

    // Ingress VC1 held by a stalled core: net_ro follows polarity
    fab_ro = 1'b0;
    net_so = 1'b1;
    net_do = 64'h0000_0000_0000_00E1;
    fab_q1.push_back(64'h0000_0000_0000_00E1);
    step();
    net_so = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ing1_stall_ro", net_ro, exp_pol ? 1'b0 : 1'b1);
      step();
    end
    fab_ro = 1'b1;
    drain(8);
    wait_pol(1'b1);
    chk("ing1_released_ro", net_ro, 1'b1);
`ifdef PORT_STATS_EN
    chk("stat_in_after_ing1", stat_in_cnt, 16'd2);
    chk("stat_out_after_ing1", stat_out_cnt, 16'd4);
`endif

    // Reset with ing_full=11 and egr_full=01: everything discarded
    fab_ro = 1'b0;
    net_ri = 1'b0;
    net_so = 1'b1;
    net_do = 64'h0000_0000_0000_00F0;
    fab_si = 1'b1;
    fab_di = 64'h0000_0000_0000_0060;
    step();
    net_do = 64'h0000_0000_0000_00F1;
    fab_si = 1'b0;
    step();
    net_so = 1'b0;
    chk("pre_rst_fab_ri", fab_ri, 2'b10);
    chk("pre_rst_net_ro", net_ro, 1'b0);
    reset  = 1'b1;
    fab_ro = 1'b1;
    net_ri = 1'b1;
    step();
    chk("mid_rst_net_ro", net_ro, 1'b1);
    chk("mid_rst_fab_ri", fab_ri, 2'b11);
    chk("mid_rst_net_si", net_si, 1'b0);
    chk("mid_rst_fab_so", fab_so, 1'b0);
    chk("mid_rst_net_di", net_di, 64'h0);
    chk("mid_rst_fab_do", fab_do, 64'h0);
`ifdef PORT_STATS_EN
    chk("mid_rst_stat_in", stat_in_cnt, 16'd0);
    chk("mid_rst_stat_out", stat_out_cnt, 16'd0);
    chk("mid_rst_stat_drop", stat_drop_cnt, 16'd0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_net_ro", net_ro, 1'b1);
      chk("post_rst_fab_ri", fab_ri, 2'b11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
